// File: rtl/instruction_fetch_unit.sv
// Fetch stage: program counter, busy-wait instruction fetch, and next-PC selection.
// Optional macro IFU_BNE_EN adds a BNE input (branch-if-not-equal).
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  input  logic [7:0]  OFFSET_8BIT,
  input  logic        JUMP,
  input  logic        BRANCH,
  input  logic        ZERO,
`ifdef IFU_BNE_EN
  input  logic        BNE,
`endif
  output logic        IMEM_READ,
  output logic [31:0] IMEM_ADDRESS,
  output logic [31:0] PC,
  output logic [31:0] INSTRUCTION,
  output logic        INSTR_VALID
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic [31:0] w_seq;
  logic [31:0] w_offset;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;
  logic        w_taken;

  // Offset counts words, so the sign-extended byte is shifted left by two;
  // the low PC bits therefore stay zero without any masking.
  assign w_seq    = r_pc + 32'd4;
  assign w_offset = {{22{OFFSET_8BIT[7]}}, OFFSET_8BIT, 2'b00};
  assign w_target = w_seq + w_offset;

`ifdef IFU_BNE_EN
  assign w_taken  = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
`else
  assign w_taken  = JUMP | (BRANCH & ZERO);
`endif

  assign w_pc_next = w_taken ? w_target : w_seq;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: if (!IMEM_BUSYWAIT) w_state_next = S_EXEC;
      S_EXEC:  if (!DMEM_BUSYWAIT) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state       <= S_FETCH;
      r_pc          <= {RESET_PC[31:2], 2'b00};
      r_instruction <= 32'h0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_FETCH && !IMEM_BUSYWAIT)
        r_instruction <= IMEM_READDATA;
      if (r_state == S_EXEC && !DMEM_BUSYWAIT)
        r_pc <= w_pc_next;
    end
  end

  // Strobes come from state alone; RESET only forces the read request low so
  // a fetch in flight is abandoned immediately.
  assign IMEM_READ    = (r_state == S_FETCH) && !RESET;
  assign INSTR_VALID  = (r_state == S_EXEC);
  assign IMEM_ADDRESS = r_pc;
  assign PC           = r_pc;
  assign INSTRUCTION  = r_instruction;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of per-instruction vectors
// plus hand-written sequences for busy-waits and reset.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic        dmem_busywait;
  logic [7:0]  offset_8bit;
  logic        jump;
  logic        branch;
  logic        zero;
`ifdef IFU_BNE_EN
  logic        bne = 1'b0;
`endif
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] data;
    logic        jump;
    logic        branch;
    logic        zero;
    logic [7:0]  offset;
    logic [31:0] pc_before;
    logic [31:0] pc_after;
  } vec_t;

  vec_t vecs[17];

  instruction_fetch_unit dut (
    .CLK           (clk),
    .RESET         (reset),
    .IMEM_READDATA (imem_readdata),
    .IMEM_BUSYWAIT (imem_busywait),
    .DMEM_BUSYWAIT (dmem_busywait),
    .OFFSET_8BIT   (offset_8bit),
    .JUMP          (jump),
    .BRANCH        (branch),
    .ZERO          (zero),
`ifdef IFU_BNE_EN
    .BNE           (bne),
`endif
    .IMEM_READ     (imem_read),
    .IMEM_ADDRESS  (imem_address),
    .PC            (pc),
    .INSTRUCTION   (instruction),
    .INSTR_VALID   (instr_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_ctrl(input logic j, input logic b, input logic z, input logic [7:0] off);
    jump        = j;
    branch      = b;
    zero        = z;
    offset_8bit = off;
  endtask

  // One full instruction: FETCH with zero-wait memory, then EXEC with no stall.
  task automatic run_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    imem_readdata = v.data;
    imem_busywait = 1'b0;
    dmem_busywait = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b1, 8'h55);  // must be ignored in FETCH
    #1;
    check($sformatf("v%0d fetch addr", idx), imem_address, v.pc_before);
    check($sformatf("v%0d fetch read", idx), {31'b0, imem_read}, 32'd1);
    check($sformatf("v%0d fetch valid", idx), {31'b0, instr_valid}, 32'd0);
    tick();
    check($sformatf("v%0d exec instr", idx), instruction, v.data);
    check($sformatf("v%0d exec valid", idx), {31'b0, instr_valid}, 32'd1);
    check($sformatf("v%0d exec read", idx), {31'b0, imem_read}, 32'd0);
    check($sformatf("v%0d exec pc held", idx), pc, v.pc_before);
    set_ctrl(v.jump, v.branch, v.zero, v.offset);
    tick();
    check($sformatf("v%0d next pc", idx), pc, v.pc_after);
    check($sformatf("v%0d back to fetch", idx), {31'b0, instr_valid}, 32'd0);
  endtask

  initial begin
    //          data          j     b     z     off    before         after
    vecs[0]  = '{32'h0000_0001, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0000, 32'h0000_0004};
    vecs[1]  = '{32'h0000_0002, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_0004, 32'h0000_0008};
    vecs[2]  = '{32'h0000_0004, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_000C, 32'h0000_0010};
    vecs[3]  = '{32'h0000_0005, 1'b1, 1'b0, 1'b0, 8'hFE, 32'h0000_0010, 32'h0000_000C};
    vecs[4]  = '{32'h0000_0006, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0000_000C, 32'h0000_0010};
    vecs[5]  = '{32'h0000_0007, 1'b1, 1'b0, 1'b0, 8'h03, 32'h0000_0010, 32'h0000_0020};
    vecs[6]  = '{32'h0000_0008, 1'b1, 1'b0, 1'b0, 8'hFB, 32'h0000_0020, 32'h0000_0010};
    vecs[7]  = '{32'h0000_0009, 1'b0, 1'b1, 1'b1, 8'h02, 32'h0000_0010, 32'h0000_001C};
    vecs[8]  = '{32'h0000_000A, 1'b1, 1'b0, 1'b0, 8'hFC, 32'h0000_001C, 32'h0000_0010};
    vecs[9]  = '{32'h0000_000B, 1'b0, 1'b1, 1'b0, 8'h02, 32'h0000_0010, 32'h0000_0014};
    vecs[10] = '{32'h0000_000C, 1'b1, 1'b1, 1'b0, 8'h01, 32'h0000_0014, 32'h0000_001C};
    vecs[11] = '{32'h0000_000D, 1'b0, 1'b1, 1'b1, 8'h00, 32'h0000_001C, 32'h0000_0020};
    vecs[12] = '{32'h0000_000E, 1'b1, 1'b0, 1'b0, 8'h80, 32'h0000_0020, 32'hFFFF_FE24};
    vecs[13] = '{32'h0000_000F, 1'b0, 1'b0, 1'b1, 8'h7F, 32'hFFFF_FE24, 32'hFFFF_FE28};
    vecs[14] = '{32'h0000_0010, 1'b1, 1'b0, 1'b0, 8'h74, 32'hFFFF_FE28, 32'hFFFF_FFFC};
    vecs[15] = '{32'h0000_0011, 1'b0, 1'b0, 1'b0, 8'h00, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[16] = '{32'h0000_0012, 1'b1, 1'b0, 1'b0, 8'h07, 32'h0000_0004, 32'h0000_0024};

    reset         = 1'b1;
    imem_readdata = 32'hDEAD_BEEF;
    imem_busywait = 1'b0;
    dmem_busywait = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    check("reset read", {31'b0, imem_read}, 32'd0);
    check("reset pc", pc, 32'h0);
    check("reset instr", instruction, 32'h0);
    check("reset valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i <= 1; i++) run_vec(i);

    // Instruction memory busy for three edges at PC=8; word latches on the fourth.
    imem_readdata = 32'h0000_0003;
    imem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ibusy%0d pc", i), pc, 32'h8);
      check($sformatf("ibusy%0d addr", i), imem_address, 32'h8);
      check($sformatf("ibusy%0d instr", i), instruction, 32'h2);
      check($sformatf("ibusy%0d read", i), {31'b0, imem_read}, 32'd1);
    end
    imem_busywait = 1'b0;
    tick();
    check("ibusy latch instr", instruction, 32'h3);
    check("ibusy latch valid", {31'b0, instr_valid}, 32'd1);
    tick();
    check("ibusy next pc", pc, 32'hC);

    for (int i = 2; i <= 15; i++) run_vec(i);

    // Data memory stall for two edges in EXEC at PC=0.
    imem_readdata = 32'h0000_0044;
    tick();
    check("dbusy instr", instruction, 32'h44);
    dmem_busywait = 1'b1;
    set_ctrl(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("dbusy%0d valid", i), {31'b0, instr_valid}, 32'd1);
      check($sformatf("dbusy%0d pc", i), pc, 32'h0);
      check($sformatf("dbusy%0d instr", i), instruction, 32'h44);
    end
    dmem_busywait = 1'b0;
    tick();
    check("dbusy pc advance", pc, 32'h4);
    check("dbusy valid drop", {31'b0, instr_valid}, 32'd0);

    run_vec(16);

    // Reset during an instruction-memory busy-wait at PC=0x24.
    imem_readdata = 32'h0000_0099;
    imem_busywait = 1'b1;
    tick();
    check("rst pre pc", pc, 32'h24);
    check("rst pre read", {31'b0, imem_read}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst read drop", {31'b0, imem_read}, 32'd0);
    tick();
    check("rst pc", pc, 32'h0);
    check("rst instr", instruction, 32'h0);
    check("rst valid", {31'b0, instr_valid}, 32'd0);
    check("rst read", {31'b0, imem_read}, 32'd0);
    reset         = 1'b0;
    imem_busywait = 1'b0;
    imem_readdata = 32'h0000_00AB;
    #1;
    check("restart addr", imem_address, 32'h0);
    check("restart read", {31'b0, imem_read}, 32'd1);
    tick();
    check("restart instr", instruction, 32'hAB);
    check("restart valid", {31'b0, instr_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
